// File: rtl/transi_sequencer_pkg.sv
// rtl/transi_sequencer_pkg.sv - shared state encodings, select constants and helpers
//
// Package transi_seq_pkg
//   seq_state_e : sequencer FSM states (IDLE / PLAY / HOLD)
//   SEL_*       : transition-pattern mux select values
//   max_int     : elaboration-time maximum of two integers
package transi_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_PLAY = 2'b01,
    ST_HOLD = 2'b10
  } seq_state_e;

  localparam logic [1:0] SEL_NADA    = 2'd0;
  localparam logic [1:0] SEL_TRANSI1 = 2'd1;
  localparam logic [1:0] SEL_TRANSI2 = 2'd2;
  localparam logic [1:0] SEL_TRANSI3 = 2'd3;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/transi_sequencer_tick_counter.sv
// rtl/transi_sequencer_tick_counter.sv - tick counter with terminal-count detect
//
// Module transi_tick_counter
//   clk_i      in   system clock
//   rst_i      in   asynchronous active-high reset
//   en_i       in   count enable (one step per enabled cycle)
//   clr_i      in   synchronous clear, wins over en_i
//   terminal_i in   terminal value; the count wraps to 0 after reaching it
//   tc_o       out  count currently equals terminal_i
module transi_tick_counter #(
  parameter int TICKWIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic                 clr_i,
  input  logic [TICKWIDTH-1:0] terminal_i,
  output logic                 tc_o
);

  logic [TICKWIDTH-1:0] count_q;
  logic [TICKWIDTH-1:0] count_d;

  assign tc_o = (count_q == terminal_i);

  // Wrapping on the terminal compare keeps the count bounded by terminal_i.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = tc_o ? '0 : count_q + TICKWIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/transi_sequencer.sv
// rtl/transi_sequencer.sv - plays one animated transition on the pattern mux
//
// Module transi_sequencer
//   TRANSI_SEQ_CLOCK_50      in   system clock
//   TRANSI_SEQ_RESET_InHigh  in   asynchronous active-high reset
//   TRANSI_SEQ_start_In      in   one-cycle start request
//   TRANSI_SEQ_level_InBUS   in   transition ID (1..3, 0 ignored)
//   TRANSI_SEQ_tick_In       in   frame-rate enable strobe
//   TRANSI_SEQ_abort_In      in   synchronous abort
//   TRANSI_SEQ_select_OutBUS out  mux select, 0 = NADA
//   TRANSI_SEQ_frame_OutBUS  out  current frame index
//   TRANSI_SEQ_busy_Out      out  transition in progress
//   TRANSI_SEQ_done_Out      out  one-cycle completion pulse
module transi_sequencer
  import transi_seq_pkg::*;
#(
  parameter int SEQ_SELECTWIDTH   = 2,
  parameter int SEQ_FRAMEWIDTH    = 3,
  parameter int SEQ_NUMFRAMES     = 8,
  parameter int SEQ_TICKWIDTH     = 8,
  parameter int SEQ_TICKSPERFRAME = 25,
  parameter int SEQ_HOLDTICKS     = 50
) (
  input  logic                       TRANSI_SEQ_CLOCK_50,
  input  logic                       TRANSI_SEQ_RESET_InHigh,
  input  logic                       TRANSI_SEQ_start_In,
  input  logic [SEQ_SELECTWIDTH-1:0] TRANSI_SEQ_level_InBUS,
  input  logic                       TRANSI_SEQ_tick_In,
  input  logic                       TRANSI_SEQ_abort_In,
  output logic [SEQ_SELECTWIDTH-1:0] TRANSI_SEQ_select_OutBUS,
  output logic [SEQ_FRAMEWIDTH-1:0]  TRANSI_SEQ_frame_OutBUS,
  output logic                       TRANSI_SEQ_busy_Out,
  output logic                       TRANSI_SEQ_done_Out
);

  localparam int MAX_TERM = max_int(SEQ_TICKSPERFRAME, SEQ_HOLDTICKS) - 1;

  localparam logic [SEQ_TICKWIDTH-1:0]  FRAME_TERM = SEQ_TICKWIDTH'(SEQ_TICKSPERFRAME - 1);
  localparam logic [SEQ_TICKWIDTH-1:0]  HOLD_TERM  = SEQ_TICKWIDTH'(SEQ_HOLDTICKS - 1);
  localparam logic [SEQ_FRAMEWIDTH-1:0] LAST_FRAME = SEQ_FRAMEWIDTH'(SEQ_NUMFRAMES - 1);
  localparam logic [SEQ_SELECTWIDTH-1:0] SEL_IDLE  = SEQ_SELECTWIDTH'(SEL_NADA);

  generate
    if (MAX_TERM >= (1 << SEQ_TICKWIDTH)) begin : g_bad_tickwidth
      $error("transi_sequencer: SEQ_TICKWIDTH too narrow for tick terminal values");
    end
    if (SEQ_NUMFRAMES < 1 || SEQ_NUMFRAMES > (1 << SEQ_FRAMEWIDTH)) begin : g_bad_numframes
      $error("transi_sequencer: SEQ_NUMFRAMES out of range for SEQ_FRAMEWIDTH");
    end
    if (SEQ_TICKSPERFRAME < 1 || SEQ_HOLDTICKS < 1) begin : g_bad_ticks
      $error("transi_sequencer: tick counts must be at least 1");
    end
  endgenerate

  seq_state_e                 state_q,  state_d;
  logic [SEQ_SELECTWIDTH-1:0] select_q, select_d;
  logic [SEQ_SELECTWIDTH-1:0] id_q,     id_d;
  logic [SEQ_FRAMEWIDTH-1:0]  frame_q,  frame_d;
  logic                       busy_q,   busy_d;
  logic                       done_q,   done_d;

  logic                       cnt_en;
  logic                       cnt_clr;
  logic                       cnt_tc;
  logic [SEQ_TICKWIDTH-1:0]   cnt_term;

  // One counter serves both phases; its terminal follows the current phase.
  // Held cleared in IDLE so a tick coincident with start is never counted.
  assign cnt_term = (state_q == ST_HOLD) ? HOLD_TERM : FRAME_TERM;
  assign cnt_clr  = TRANSI_SEQ_abort_In || (state_q == ST_IDLE);
  assign cnt_en   = TRANSI_SEQ_tick_In;

  transi_tick_counter #(
    .TICKWIDTH(SEQ_TICKWIDTH)
  ) u_tick_counter (
    .clk_i      (TRANSI_SEQ_CLOCK_50),
    .rst_i      (TRANSI_SEQ_RESET_InHigh),
    .en_i       (cnt_en),
    .clr_i      (cnt_clr),
    .terminal_i (cnt_term),
    .tc_o       (cnt_tc)
  );

  always_comb begin
    state_d  = state_q;
    select_d = select_q;
    id_d     = id_q;
    frame_d  = frame_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    if (TRANSI_SEQ_abort_In) begin
      // Abort drops any start in IDLE and never produces a done pulse.
      if (state_q != ST_IDLE) begin
        state_d  = ST_IDLE;
        select_d = SEL_IDLE;
        frame_d  = '0;
        busy_d   = 1'b0;
      end
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (TRANSI_SEQ_start_In && (TRANSI_SEQ_level_InBUS != '0)) begin
            state_d  = ST_PLAY;
            id_d     = TRANSI_SEQ_level_InBUS;
            select_d = TRANSI_SEQ_level_InBUS;
            frame_d  = '0;
            busy_d   = 1'b1;
          end
        end
        ST_PLAY: begin
          if (TRANSI_SEQ_tick_In && cnt_tc) begin
            if (frame_q < LAST_FRAME) begin
              frame_d = frame_q + SEQ_FRAMEWIDTH'(1);
            end else begin
              state_d = ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (TRANSI_SEQ_tick_In && cnt_tc) begin
            state_d  = ST_IDLE;
            select_d = SEL_IDLE;
            frame_d  = '0;
            busy_d   = 1'b0;
            done_d   = 1'b1;
          end
        end
        default: begin
          state_d  = ST_IDLE;
          select_d = SEL_IDLE;
          frame_d  = '0;
          busy_d   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge TRANSI_SEQ_CLOCK_50 or posedge TRANSI_SEQ_RESET_InHigh) begin
    if (TRANSI_SEQ_RESET_InHigh) begin
      state_q  <= ST_IDLE;
      select_q <= '0;
      id_q     <= '0;
      frame_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      select_q <= select_d;
      id_q     <= id_d;
      frame_q  <= frame_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign TRANSI_SEQ_select_OutBUS = select_q;
  assign TRANSI_SEQ_frame_OutBUS  = frame_q;
  assign TRANSI_SEQ_busy_Out      = busy_q;
  assign TRANSI_SEQ_done_Out      = done_q;

endmodule

// File: tb/tb_transi_sequencer.sv
// tb/tb_transi_sequencer.sv - self-checking bench for transi_sequencer
module tb_transi_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [1:0] level = 2'd0;
  logic       tick = 1'b0;
  logic       abort = 1'b0;
  logic [1:0] sel;
  logic [2:0] frame;
  logic       busy;
  logic       done;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  transi_sequencer #(
    .SEQ_SELECTWIDTH   (2),
    .SEQ_FRAMEWIDTH    (3),
    .SEQ_NUMFRAMES     (4),
    .SEQ_TICKWIDTH     (8),
    .SEQ_TICKSPERFRAME (2),
    .SEQ_HOLDTICKS     (3)
  ) dut (
    .TRANSI_SEQ_CLOCK_50      (clk),
    .TRANSI_SEQ_RESET_InHigh  (rst),
    .TRANSI_SEQ_start_In      (start),
    .TRANSI_SEQ_level_InBUS   (level),
    .TRANSI_SEQ_tick_In       (tick),
    .TRANSI_SEQ_abort_In      (abort),
    .TRANSI_SEQ_select_OutBUS (sel),
    .TRANSI_SEQ_frame_OutBUS  (frame),
    .TRANSI_SEQ_busy_Out      (busy),
    .TRANSI_SEQ_done_Out      (done)
  );

  typedef struct {
    string      name;
    logic       start;
    logic [1:0] level;
    logic       tick;
    logic       abort;
    logic [1:0] sel;
    logic [2:0] frame;
    logic       busy;
    logic       done;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input string name, input logic st, input logic [1:0] lv,
                     input logic tk, input logic ab, input logic [1:0] es,
                     input logic [2:0] ef, input logic eb, input logic ed);
    vec_t v;
    v.name = name; v.start = st; v.level = lv; v.tick = tk; v.abort = ab;
    v.sel = es; v.frame = ef; v.busy = eb; v.done = ed;
    vecs.push_back(v);
  endtask

  // A full run with NUMFRAMES=4, TICKSPERFRAME=2, HOLDTICKS=3, tick every cycle:
  // frames seen after each edge are 0,0,1,1,2,2,3,3 then 3,3,3 held, then done.
  // restart_at injects a second start while busy; abort_at aborts at that row.
  task automatic add_run(input string name, input logic [1:0] lv,
                         input int restart_at, input logic [1:0] lv2, input int abort_at);
    int fr[11] = '{0, 0, 1, 1, 2, 2, 3, 3, 3, 3, 3};
    for (int i = 0; i < 11; i++) begin
      if (i == abort_at) begin
        add(name, 1'b0, 2'd0, 1'b1, 1'b1, 2'd0, 3'd0, 1'b0, 1'b0);
        add(name, 1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 3'd0, 1'b0, 1'b0);
        return;
      end
      if (i == 0)
        add(name, 1'b1, lv, 1'b1, 1'b0, lv, fr[i][2:0], 1'b1, 1'b0);
      else if (i == restart_at)
        add(name, 1'b1, lv2, 1'b1, 1'b0, lv, fr[i][2:0], 1'b1, 1'b0);
      else
        add(name, 1'b0, 2'd0, 1'b1, 1'b0, lv, fr[i][2:0], 1'b1, 1'b0);
    end
    add(name, 1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 3'd0, 1'b0, 1'b1);
    add(name, 1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 3'd0, 1'b0, 1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int busy_cnt;
    int done_cnt;
    int done_at;
    int frame_at[41];

    // Reset state
    #2;
    check("reset_outputs", {sel, frame, busy, done}, 0);
    @(negedge clk);
    rst = 1'b0;
    step();

    add_run("normal_run", 2'd2, -1, 2'd0, -1);
    add("invalid_start", 1'b1, 2'd0, 1'b1, 1'b0, 2'd0, 3'd0, 1'b0, 1'b0);
    add("invalid_start", 1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 3'd0, 1'b0, 1'b0);
    add("abort_start_idle", 1'b1, 2'd1, 1'b1, 1'b1, 2'd0, 3'd0, 1'b0, 1'b0);
    add("abort_idle", 1'b0, 2'd0, 1'b1, 1'b1, 2'd0, 3'd0, 1'b0, 1'b0);
    add("idle", 1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 3'd0, 1'b0, 1'b0);
    add_run("start_while_busy", 2'd1, 3, 2'd3, -1);
    add_run("abort_in_hold", 2'd2, -1, 2'd0, 10);
    add_run("run_after_abort", 2'd3, -1, 2'd0, -1);

    foreach (vecs[i]) begin
      start = vecs[i].start;
      level = vecs[i].level;
      tick  = vecs[i].tick;
      abort = vecs[i].abort;
      step();
      check($sformatf("%s[%0d] {sel,frame,busy,done}", vecs[i].name, i),
            {sel, frame, busy, done},
            {vecs[i].sel, vecs[i].frame, vecs[i].busy, vecs[i].done});
    end
    start = 1'b0; level = 2'd0; tick = 1'b0; abort = 1'b0;
    step();

    // Sparse ticks: one tick every third cycle, start cycle has no tick.
    busy_cnt = 0; done_cnt = 0; done_at = -1;
    for (int k = 0; k <= 40; k++) begin
      start = (k == 0);
      level = 2'd1;
      tick  = (k > 0) && (k % 3 == 0);
      step();
      busy_cnt += int'(busy);
      done_cnt += int'(done);
      if (done) done_at = k;
      frame_at[k] = int'(frame);
      if (k < 33) check($sformatf("sparse_select[%0d]", k), sel, 1);
    end
    start = 1'b0; level = 2'd0; tick = 1'b0;
    check("sparse_busy_cycles", busy_cnt, 33);
    check("sparse_done_count", done_cnt, 1);
    check("sparse_done_edge", done_at, 33);
    check("sparse_frame_e5", frame_at[5], 0);
    check("sparse_frame_e6", frame_at[6], 1);
    check("sparse_frame_e11", frame_at[11], 1);
    check("sparse_frame_e12", frame_at[12], 2);
    check("sparse_frame_e18", frame_at[18], 3);
    check("sparse_frame_e32", frame_at[32], 3);
    check("sparse_frame_e33", frame_at[33], 0);

    // Async reset mid-PLAY at frame 2
    start = 1'b1; level = 2'd2; tick = 1'b1;
    step();
    start = 1'b0; level = 2'd0;
    for (int k = 0; k < 4; k++) step();
    check("pre_reset_frame", frame, 2);
    check("pre_reset_busy", busy, 1);
    #2;
    rst = 1'b1;
    #1;
    check("async_reset_outputs", {sel, frame, busy, done}, 0);
    @(negedge clk);
    rst = 1'b0;
    step();
    check("post_reset_idle", {sel, frame, busy, done}, 0);
    step();
    check("post_reset_still_idle", {sel, frame, busy, done}, 0);
    start = 1'b1; level = 2'd3;
    step();
    start = 1'b0; level = 2'd0;
    check("post_reset_start", {sel, frame, busy, done}, {2'd3, 3'd0, 1'b1, 1'b0});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/transi_sequencer.md
Name: transi_sequencer

Overview:
Sequencer that drives the select input of the transition-pattern 4:1 mux (NADA / TRANSI1 / TRANSI2 / TRANSI3) and plays one animated transition.
- Accepts a one-cycle start request carrying a transition ID.
- Steps a frame index at a tick-derived rate, holds the last frame, then returns the mux to NADA.
- Signals completion to the game controller with a done pulse.

Parameters:
- SEQ_SELECTWIDTH, 2, width of mux select / transition ID.
- SEQ_FRAMEWIDTH, 3, width of frame index.
- SEQ_NUMFRAMES, 8, frames per transition; legal range 1..2^SEQ_FRAMEWIDTH.
- SEQ_TICKWIDTH, 8, width of internal tick counter.
- SEQ_TICKSPERFRAME, 25, tick_In strobes per frame; minimum 1.
- SEQ_HOLDTICKS, 50, tick_In strobes the last frame is held; minimum 1.

Ports:
- TRANSI_SEQ_CLOCK_50  in  1  system clock.
- TRANSI_SEQ_RESET_InHigh  in  1  asynchronous, active-high reset.
- TRANSI_SEQ_start_In  in  1  one-cycle start request.
- TRANSI_SEQ_level_InBUS  in  SEQ_SELECTWIDTH  transition ID, 1..3; 0 is invalid.
- TRANSI_SEQ_tick_In  in  1  frame-rate enable strobe from the prescaler.
- TRANSI_SEQ_abort_In  in  1  synchronous abort.
- TRANSI_SEQ_select_OutBUS  out  SEQ_SELECTWIDTH  mux select; 0 = NADA.
- TRANSI_SEQ_frame_OutBUS  out  SEQ_FRAMEWIDTH  current frame index.
- TRANSI_SEQ_busy_Out  out  1  transition in progress.
- TRANSI_SEQ_done_Out  out  1  one-cycle completion pulse.

Behaviour:
- Clocking and reset:
  - Single clock. Reset is asynchronous and active-high; all outputs are registered.
  - On reset: state=IDLE, select=0, frame=0, busy=0, done=0, tick counter=0, latched ID=0.
  - Reset takes effect immediately, including mid-transition.
- FSM states: IDLE, PLAY, HOLD.
- IDLE:
  - On start=1 and level!=0: latch level and enter PLAY.
  - Registered at that same edge: select=level, frame=0, busy=1, tick counter=0.
  - Latency from the start edge to valid select/busy is 1 cycle.
  - start with level=0: ignored, remain IDLE.
  - A tick coincident with start is not counted.
- PLAY:
  - Each tick increments the tick counter.
  - On a tick with counter==SEQ_TICKSPERFRAME-1: clear the counter.
    - If frame<SEQ_NUMFRAMES-1: frame++.
    - Else (frame==SEQ_NUMFRAMES-1): enter HOLD, frame stays at NUMFRAMES-1.
- HOLD:
  - Each tick increments the counter.
  - On a tick with counter==SEQ_HOLDTICKS-1, at that edge: select=0, frame=0, busy=0, done=1, counter=0, state=IDLE.
  - done returns to 0 on the next edge.
- Duration: busy is high for exactly SEQ_NUMFRAMES*SEQ_TICKSPERFRAME+SEQ_HOLDTICKS ticks.
- Start while busy: ignored, with no queueing; the latched ID is unchanged.
- Abort:
  - Abort in PLAY/HOLD: next edge gives IDLE, select=0, frame=0, busy=0, counter=0, and no done pulse.
  - Abort has priority over tick and start in the same cycle.
  - Abort in IDLE with simultaneous start: start is dropped.
  - Abort in IDLE alone: no effect.
- Widths: the tick counter saturates nowhere; the terminal compare guarantees it never exceeds max(TICKSPERFRAME,HOLDTICKS)-1. That value must fit in SEQ_TICKWIDTH (elaboration check).
- select stays constant for the whole of PLAY+HOLD; the mux output never glitches between IDs.

Decomposition:
- Package transi_seq_pkg:
  - state encodings IDLE=2'b00, PLAY=2'b01, HOLD=2'b10.
  - select constants NADA=0, TRANSI1=1, TRANSI2=2, TRANSI3=3.
- Sub-module transi_tick_counter: enable, synchronous clear, terminal-value input, terminal-count output. It is reused for the frame (PLAY) and hold (HOLD) phases.

Test Plan:
Unless stated otherwise, parameters are NUMFRAMES=4, TICKSPERFRAME=2, HOLDTICKS=3, and tick_In=1 every cycle.
1. Normal run: start=1, level=2 for one cycle -> next cycle select=2, busy=1; frame sequence 0,0,1,1,2,2,3,3, then 3,3,3 (hold); busy high exactly 11 cycles; done=1 for 1 cycle as busy falls, select=0.
2. Invalid start: start=1, level=0 -> select=0, busy=0, done never asserted.
3. Start while busy: level=1 run, then start with level=3 at frame 1 -> select stays 1; total duration unchanged at 11 cycles.
4. Abort in HOLD: abort=1 at second hold cycle -> next cycle select=0, frame=0, busy=0; done stays 0; a subsequent start with level=3 runs normally.
5. Sparse ticks: tick every 3rd cycle, level=1 -> frame advances every 6 cycles; busy high 33 cycles.
6. Async reset mid-PLAY: RESET_InHigh asserted between clock edges at frame 2 -> select, frame, busy, done all 0 immediately, before the next edge; IDLE after release.
